// File: rtl/sw_event_gen_if.sv
// Signal bundle between the switch event generator and its user:
// timebase tick and debounced level in, registered event pulses out.
interface sw_event_gen_if;
    logic iCke;
    logic iUserSw;
    logic oPress;
    logic oRelease;
    logic oClick;
    logic oDblClick;
    logic oLongPress;
    logic oRepeat;
    logic oBusy;

    modport slave (
        input  iCke, iUserSw,
        output oPress, oRelease, oClick, oDblClick, oLongPress, oRepeat, oBusy
    );

    modport master (
        output iCke, iUserSw,
        input  oPress, oRelease, oClick, oDblClick, oLongPress, oRepeat, oBusy
    );
endinterface

// File: rtl/sw_event_gen.sv
// Turns a debounced switch level into single-cycle press/release/click/
// double-click/long-press/repeat pulses, timed by the debouncer's tick.
module sw_event_gen #(
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int DBL_TICKS    = 300,
    parameter int CNT_W        = 12
) (
    input  logic           iSysClk,
    input  logic           iSysRst,
    sw_event_gen_if.slave  ev
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        LONG,
        WAIT2,
        DBLHOLD
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             prev;
    logic             rise, fall;
    logic             press_n, release_n, click_n, dbl_n, long_n, repeat_n;

    // prev resets high so a switch held through reset release is not a press
    assign rise = ev.iUserSw & ~prev;
    assign fall = ~ev.iUserSw & prev;

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            state         <= IDLE;
            cnt           <= '0;
            prev          <= 1'b1;
            ev.oPress     <= 1'b0;
            ev.oRelease   <= 1'b0;
            ev.oClick     <= 1'b0;
            ev.oDblClick  <= 1'b0;
            ev.oLongPress <= 1'b0;
            ev.oRepeat    <= 1'b0;
            ev.oBusy      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            prev          <= ev.iUserSw;
            ev.oPress     <= press_n;
            ev.oRelease   <= release_n;
            ev.oClick     <= click_n;
            ev.oDblClick  <= dbl_n;
            ev.oLongPress <= long_n;
            ev.oRepeat    <= repeat_n;
            ev.oBusy      <= (state_n != IDLE);
        end
    end

    // Edges are tested before ticks in every state, so an edge on the same
    // clock as a terminal tick wins and the tick event is dropped.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        click_n   = 1'b0;
        dbl_n     = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    press_n = 1'b1;
                    cnt_n   = '0;
                    state_n = PRESS;
                end
            end
            PRESS: begin
                if (fall) begin
                    release_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = WAIT2;
                end else if (ev.iCke) begin
                    if (cnt == LONG_LAST) begin
                        long_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = LONG;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    release_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (ev.iCke) begin
                    if (cnt == REPEAT_LAST) begin
                        repeat_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            WAIT2: begin
                if (rise) begin
                    press_n = 1'b1;
                    dbl_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = DBLHOLD;
                end else if (ev.iCke) begin
                    if (cnt == DBL_LAST) begin
                        click_n = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            DBLHOLD: begin
                if (fall) begin
                    release_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule
